// File: rtl/sparse_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sparse_write_buffer
// Description : Reorder buffer. Slots are allocated in order (alloc_ptr is the
//               granted slot), filled by pointer in any order, and drained in
//               allocation order as soon as the head slot has been written.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst       : rising-edge clock, synchronous active-high reset
//   alloc_valid    : request the next slot
//   alloc_enable   : a slot is free (buffer not full)
//   alloc_ptr      : slot granted when alloc_valid & alloc_enable
//   write_valid    : write request (always accepted, never stalled)
//   write_ptr      : target slot of the write
//   write_data     : data stored into the target slot
//   write_error    : one-cycle pulse, previous write was rejected
//   drain_valid    : head slot holds written data
//   drain_enable   : consumer takes the head entry
//   drain_data     : head data, zero when drain_valid is low
//   entry_alloc    : per-slot allocated flags
//   entry_valid    : per-slot written flags
//   count          : number of allocated slots, 0..SWB_DEPTH
// ============================================================================
module sparse_write_buffer #(
    parameter int SWB_DEPTH = 16,
    parameter int SWB_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    output logic                         alloc_enable,
    output logic [$clog2(SWB_DEPTH)-1:0] alloc_ptr,
    input  logic                         write_valid,
    input  logic [$clog2(SWB_DEPTH)-1:0] write_ptr,
    input  logic [SWB_WIDTH-1:0]         write_data,
    output logic                         write_error,
    output logic                         drain_valid,
    input  logic                         drain_enable,
    output logic [SWB_WIDTH-1:0]         drain_data,
    output logic [SWB_DEPTH-1:0]         entry_alloc,
    output logic [SWB_DEPTH-1:0]         entry_valid,
    output logic [$clog2(SWB_DEPTH):0]   count
);

    localparam int AW = $clog2(SWB_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [SWB_DEPTH-1:0] ONE_HOT_0 = {{(SWB_DEPTH-1){1'b0}}, 1'b1};

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]        r_head;
    logic [PW-1:0]        r_tail;
    logic [SWB_DEPTH-1:0] r_alloc;
    logic [SWB_DEPTH-1:0] r_valid;
    logic                 r_write_error;
    logic [SWB_WIDTH-1:0] r_mem [SWB_DEPTH];

    logic [AW-1:0]        w_head_slot;
    logic [AW-1:0]        w_tail_slot;
    logic                 w_full;
    logic                 w_alloc_fire;
    logic                 w_drain_fire;
    logic                 w_write_ok;
    logic [SWB_DEPTH-1:0] w_alloc_set;
    logic [SWB_DEPTH-1:0] w_valid_set;
    logic [SWB_DEPTH-1:0] w_drain_clr;

    assign w_head_slot = r_head[AW-1:0];
    assign w_tail_slot = r_tail[AW-1:0];
    assign w_full      = (w_head_slot == w_tail_slot) && (r_head[AW] != r_tail[AW]);

    // Full-plus-drain does not free a slot until the next cycle: alloc_enable
    // is derived from registered pointers only.
    assign w_alloc_fire = alloc_valid & ~w_full;

    // An empty buffer has an unallocated, hence unwritten, head slot, so
    // drain_enable is naturally ignored there.
    assign w_drain_fire = r_valid[w_head_slot] & drain_enable;

    // Flags are checked before this cycle's alloc takes effect, which makes a
    // write to the slot being allocated this cycle illegal. A write to the
    // head while it drains is illegal too, because the head is already valid.
    assign w_write_ok = write_valid & r_alloc[write_ptr] & ~r_valid[write_ptr];

    always_comb begin
        w_alloc_set = '0;
        w_valid_set = '0;
        w_drain_clr = '0;
        if (w_alloc_fire) begin
            w_alloc_set = ONE_HOT_0 << w_tail_slot;
        end
        if (w_write_ok) begin
            w_valid_set = ONE_HOT_0 << write_ptr;
        end
        if (w_drain_fire) begin
            w_drain_clr = ONE_HOT_0 << w_head_slot;
        end
    end

    // Control state: pointers, flags and the error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_alloc       <= '0;
            r_valid       <= '0;
            r_write_error <= 1'b0;
        end else begin
            if (w_alloc_fire) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_drain_fire) begin
                r_head <= r_head + PW'(1);
            end
            // Set and clear masks never overlap: alloc targets a free slot,
            // a legal write targets a non-head-valid slot.
            r_alloc       <= (r_alloc | w_alloc_set) & ~w_drain_clr;
            r_valid       <= (r_valid | w_valid_set) & ~w_drain_clr;
            r_write_error <= write_valid & ~w_write_ok;
        end
    end

    // Storage has no reset; validity comes from the flags alone.
    generate
        for (genvar gi = 0; gi < SWB_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (w_valid_set[gi]) begin
                    r_mem[gi] <= write_data;
                end
            end
        end
    endgenerate

    assign alloc_enable = ~w_full;
    assign alloc_ptr    = w_tail_slot;
    assign write_error  = r_write_error;
    assign drain_valid  = r_valid[w_head_slot];
    assign drain_data   = r_valid[w_head_slot] ? r_mem[w_head_slot] : '0;
    assign entry_alloc  = r_alloc;
    assign entry_valid  = r_valid;
    assign count        = r_tail - r_head;

endmodule

`default_nettype wire

// File: tb/tb_sparse_write_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparse_write_buffer
// Description : Self-checking bench for sparse_write_buffer (depth 4, width 8).
//               A slot-array model with unbounded head/tail counters predicts
//               every output each cycle; directed sequences add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_write_buffer;

    localparam int D = 4;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         alloc_valid;
    logic         alloc_enable;
    logic [1:0]   alloc_ptr;
    logic         write_valid;
    logic [1:0]   write_ptr;
    logic [W-1:0] write_data;
    logic         write_error;
    logic         drain_valid;
    logic         drain_enable;
    logic [W-1:0] drain_data;
    logic [D-1:0] entry_alloc;
    logic [D-1:0] entry_valid;
    logic [2:0]   count;

    sparse_write_buffer #(.SWB_DEPTH(D), .SWB_WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .alloc_valid  (alloc_valid),
        .alloc_enable (alloc_enable),
        .alloc_ptr    (alloc_ptr),
        .write_valid  (write_valid),
        .write_ptr    (write_ptr),
        .write_data   (write_data),
        .write_error  (write_error),
        .drain_valid  (drain_valid),
        .drain_enable (drain_enable),
        .drain_data   (drain_data),
        .entry_alloc  (entry_alloc),
        .entry_valid  (entry_valid),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int  m_head;          // number of entries ever drained since reset
    int  m_tail;          // number of entries ever allocated since reset
    bit  m_alloc [D];
    bit  m_valid [D];
    int  m_data  [D];
    bit  m_werr;
    bit  m_started = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_head = 0;
            m_tail = 0;
            for (int i = 0; i < D; i++) begin
                m_alloc[i] = 1'b0;
                m_valid[i] = 1'b0;
            end
            m_werr    = 1'b0;
            m_started = 1'b1;
        end else if (m_started) begin
            bit afire, dfire, legal;
            int hs, ts, wp;
            hs    = m_head % D;
            ts    = m_tail % D;
            wp    = int'(write_ptr);
            afire = alloc_valid && ((m_tail - m_head) < D);
            dfire = m_valid[hs] && drain_enable;
            legal = write_valid && m_alloc[wp] && !m_valid[wp];
            m_werr = write_valid && !legal;
            if (legal) begin
                m_valid[wp] = 1'b1;
                m_data[wp]  = int'(write_data);
            end
            if (afire) begin
                m_alloc[ts] = 1'b1;
                m_tail++;
            end
            if (dfire) begin
                m_alloc[hs] = 1'b0;
                m_valid[hs] = 1'b0;
                m_head++;
            end
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Outputs depend only on registered state, so they are sampled on the
    // falling edge against the model state updated at the rising edge.
    always @(negedge clk) begin
        if (m_started) begin
            int hs;
            logic [D-1:0] ea, ev;
            hs = m_head % D;
            for (int i = 0; i < D; i++) begin
                ea[i] = m_alloc[i];
                ev[i] = m_valid[i];
            end
            cmp("alloc_enable", int'(alloc_enable), int'((m_tail - m_head) < D));
            cmp("alloc_ptr",    int'(alloc_ptr),    m_tail % D);
            cmp("count",        int'(count),        m_tail - m_head);
            cmp("entry_alloc",  int'(entry_alloc),  int'(ea));
            cmp("entry_valid",  int'(entry_valid),  int'(ev));
            cmp("drain_valid",  int'(drain_valid),  int'(m_valid[hs]));
            cmp("drain_data",   int'(drain_data),   m_valid[hs] ? m_data[hs] : 0);
            cmp("write_error",  int'(write_error),  int'(m_werr));
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change just after a falling edge and are held through the next
    // rising edge; the task returns at the following falling edge.
    task automatic step(input logic rs, input logic av, input logic de,
                        input logic wv, input logic [1:0] wp, input logic [7:0] wd);
        rst          = rs;
        alloc_valid  = av;
        drain_enable = de;
        write_valid  = wv;
        write_ptr    = wp;
        write_data   = wd;
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    endtask

    initial begin
        rst = 1'b1; alloc_valid = 1'b0; drain_enable = 1'b0;
        write_valid = 1'b0; write_ptr = '0; write_data = '0;
        @(negedge clk);
        do_reset();

        // Reset values.
        cmp("rst_count",        int'(count),        0);
        cmp("rst_alloc_enable", int'(alloc_enable), 1);
        cmp("rst_drain_data",   int'(drain_data),   0);

        // Four allocations fill the buffer; a fifth is not granted.
        for (int i = 0; i < 4; i++) begin
            cmp("fill_alloc_ptr", int'(alloc_ptr), i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        end
        cmp("fill_count",        int'(count),        4);
        cmp("fill_alloc_enable", int'(alloc_enable), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        cmp("fifth_alloc_count", int'(count),        4);

        // Out-of-order fill with drain enabled.
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 8'h22);
        cmp("ooo_no_drain", int'(drain_valid), 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 8'h00);
        cmp("ooo_d0_valid", int'(drain_valid), 1);
        cmp("ooo_d0",       int'(drain_data),  8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11);
        cmp("ooo_d1",       int'(drain_data),  8'h11);
        step(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h33);
        cmp("ooo_d2",       int'(drain_data),  8'h22);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        cmp("ooo_d3",       int'(drain_data),  8'h33);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        cmp("ooo_empty_count", int'(count), 0);

        // Illegal writes.
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h00);
        cmp("legal_no_err", int'(write_error), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h77);
        cmp("unalloc_err", int'(write_error), 1);
        idle();
        cmp("unalloc_err_clear", int'(write_error), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'hFF);
        cmp("double_err", int'(write_error), 1);
        idle();
        cmp("double_err_clear", int'(write_error), 0);
        cmp("slot0_kept",       int'(drain_data),  8'h00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);

        // Full and drain in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'hA0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00);
        cmp("fulldrain_count",  int'(count),        3);
        cmp("fulldrain_enable", int'(alloc_enable), 1);
        cmp("fulldrain_ptr",    int'(alloc_ptr),    0);

        // Wrap: ten round trips through a depth-4 buffer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'(8'h50 + i);
            step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
            step(1'b0, 1'b0, 1'b0, 1'b1, 2'(i % 4), d);
            cmp("wrap_data", int'(drain_data), int'(d));
            step(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
        end
        cmp("wrap_count", int'(count), 0);

        // Reset in the middle of operation.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h10);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 8'h11);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 8'h12);
        cmp("mid_rst_alloc", int'(entry_alloc), 0);
        cmp("mid_rst_valid", int'(entry_valid), 0);
        cmp("mid_rst_count", int'(count),       0);
        cmp("mid_rst_dv",    int'(drain_valid), 0);
        cmp("mid_rst_ptr",   int'(alloc_ptr),   0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 8'h99);
        cmp("mid_rst_werr",  int'(write_error), 1);

        // Random traffic, checked every cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            logic rs, av, de, wv;
            logic [1:0] wp;
            rs = ($urandom_range(0, 249) == 0);
            av = ($urandom_range(0, 99) < 55);
            de = ($urandom_range(0, 99) < 50);
            wv = ($urandom_range(0, 99) < 60);
            // Mostly aim writes inside the allocated window to reach drains.
            if ($urandom_range(0, 3) != 0 && m_tail != m_head)
                wp = 2'((m_head + $urandom_range(0, m_tail - m_head - 1)) % D);
            else
                wp = 2'($urandom_range(0, D - 1));
            step(rs, av, de, wv, wp, 8'($urandom));
        end

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sparse_write_buffer.md
# sparse_write_buffer

In-order-allocate, out-of-order-write, in-order-drain buffer (reorder buffer). Requesters allocate slots sequentially and receive a slot pointer. Responses later fill those slots by pointer in any order, and the block drains entries strictly in allocation order as each head entry becomes valid. It sits on the response side of the cache, opposite the sparse read buffer: that buffer writes in order and reads by pointer, while this block writes by pointer and reads in order.

## Interface
- SWB_DEPTH, 16, number of slots; power of two, ≥2
- SWB_WIDTH, 8, data bits per slot
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- alloc_valid  in  1  request to allocate next slot
- alloc_enable  out  1  slot available (buffer not full)
- alloc_ptr  out  $clog2(SWB_DEPTH)  slot index granted on alloc fire
- write_valid  in  1  write request
- write_ptr  in  $clog2(SWB_DEPTH)  target slot
- write_data  in  SWB_WIDTH  data for slot
- write_error  out  1  registered one-cycle pulse: previous write was rejected
- drain_valid  out  1  head slot holds valid data
- drain_enable  in  1  consumer accepts head
- drain_data  out  SWB_WIDTH  head data; 0 when drain_valid=0
- entry_alloc  out  SWB_DEPTH  per-slot allocated flags
- entry_valid  out  SWB_DEPTH  per-slot written flags
- count  out  $clog2(SWB_DEPTH)+1  allocated-slot count, 0..SWB_DEPTH

## Operation
- Pointers:
  - head and tail are $clog2(SWB_DEPTH)+1 bits wide; the MSB is a wrap bit.
  - The slot index is the low bits of each pointer.
  - count = tail − head, truncated to pointer width.
  - Empty when head==tail. Full when the low bits are equal and the MSBs differ.
- Allocate:
  - alloc_enable = !full.
  - Fire = alloc_valid & alloc_enable.
  - alloc_ptr = tail low bits, presented combinationally.
  - On fire, set entry_alloc[alloc_ptr] and increment tail; the pointer wraps modulo 2·SWB_DEPTH.
- Write:
  - The block accepts every write_valid; there is no backpressure.
  - Legal when entry_alloc[write_ptr]=1 and entry_valid[write_ptr]=0. Then store write_data and set entry_valid[write_ptr].
  - Illegal when the slot is unallocated or already valid. The write is dropped, storage and flags are unchanged, and write_error=1 in the next cycle.
- Drain:
  - drain_valid = entry_valid[head slot].
  - drain_data = drain_valid ? array[head slot] : 0.
  - Fire = drain_valid & drain_enable. It clears entry_alloc and entry_valid for the head slot and increments head.
  - Entries behind an unwritten head are never presented, even if they are valid.
- Storage holds its value when not written. Flags are the only source of validity.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - head=tail=0, entry_alloc=0, entry_valid=0, count=0.
  - alloc_enable=1, alloc_ptr=0.
  - drain_valid=0, drain_data=0, write_error=0.
- rst asserted mid-operation discards all slots and outstanding pointers. Writes and allocs in the reset cycle are ignored.
- An alloc fire in cycle N makes the slot writable from cycle N+1. A same-cycle write to a slot being allocated is illegal.
- A legal write in cycle N raises drain_valid no earlier than N+1. There is no write-to-drain bypass.
- A drain fire in cycle N advances head at N+1. The new head's drain_valid is evaluated from flags at N+1.
- Alloc and drain in the same cycle are both honoured: count unchanged, tail and head each advance.
- Full plus drain in the same cycle: alloc_enable is from registered state and stays 0. The freed slot becomes allocatable at N+1.
- Empty: drain_valid=0, and drain_enable is ignored.
- A write and a drain to the same slot in the same cycle is always illegal, because the head is already valid. write_error pulses and the drain proceeds.
- Pointer wrap after 2·SWB_DEPTH allocations has no effect on behaviour.

## Test plan
Directed scenarios use SWB_DEPTH=4, SWB_WIDTH=8.
- Reset, then 4 allocs: alloc_ptr 0,1,2,3; count 4; alloc_enable=0 after the 4th fire; a 5th alloc_valid is not granted.
- Out-of-order fill with drain_enable=1:
  - Write slot2=0x22, then slot0=0x00, then slot1=0x11, then slot3=0x33.
  - Drain order is 0x00, 0x11, 0x22, 0x33.
  - No drain while slot0 is unwritten.
  - Each data item appears 1 cycle after the write that completes the contiguous prefix.
- Illegal writes: a write to unallocated slot1, and a second write to valid slot0 with 0xFF.
  - write_error pulses for exactly one cycle each.
  - Slot0 still drains 0x00.
- Full and drain together: buffer full and head valid; assert alloc_valid and drain_enable in one cycle.
  - Drain fires and alloc is refused that cycle.
  - Next cycle alloc_enable=1 and alloc_ptr equals the old head slot.
- Wrap: 10 alloc/write/drain round trips with data 0x50+i. Drained data matches in order, and count returns to 0.
- Mid-operation reset: with 3 slots allocated and 2 valid, pulse rst for one cycle.
  - All flags 0, count 0, drain_valid 0, alloc_ptr 0.
  - A subsequent write to slot0 raises write_error.
